// File: rtl/half_duplex_pkg.sv
// Shared types for the half-duplex bus controller: FSM state encoding and the
// helper that sizes the burst and turnaround counters.
package half_duplex_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        TX   = 2'd1,
        TURN = 2'd2,
        RX   = 2'd3
    } state_t;

    // Bits needed to hold the values 0..max_val inclusive.
    function automatic int cnt_w(input int max_val);
        if (max_val < 1)
            return 1;
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/turn_timer.sv
// Loadable down-counter that measures the released-bus turnaround window.
// done pulses on the last ticked cycle of the window.
module turn_timer
    import half_duplex_pkg::*;
#(
    parameter int TURN_CYC = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic tick,
    output logic done
);

    localparam int CW = cnt_w(TURN_CYC);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= CW'(TURN_CYC);
        else if (tick && (cnt != '0))
            cnt <= cnt - CW'(1);
    end

    assign done = tick && (cnt == CW'(1));

endmodule

// File: rtl/half_duplex_bus_ctrl.sv
// Far-end controller for a shared tri-state bus: owns TX/RX direction switching
// with enforced turnaround. Optional feature macro: HALF_DUPLEX_COLLISION_DETECT_EN.
module half_duplex_bus_ctrl
    import half_duplex_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int TURN_CYC  = 2,
    parameter int MAX_BURST = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tx_valid,
    input  logic [WIDTH-1:0] tx_data,
    output logic             tx_ready,
    input  logic             rx_en,
    output logic             rx_valid,
    output logic [WIDTH-1:0] rx_data,
    input  logic [WIDTH-1:0] bus_in,
    input  logic             bus_stb_in,
    output logic [WIDTH-1:0] bus_out,
    output logic             bus_oe,
    output logic             bus_stb_out,
    output logic             busy,
    output logic             collision
);

    localparam int BURST_W = cnt_w(MAX_BURST);

    state_t             state;
    state_t             state_next;
    logic [BURST_W-1:0] burst_cnt;
    logic               accept;
    logic               enter_turn;
    logic               turn_done;
    logic               col_hit;

    assign tx_ready = (state == TX) && (burst_cnt < BURST_W'(MAX_BURST));
    assign busy     = (state != IDLE);
    assign accept   = tx_valid && tx_ready;

`ifdef HALF_DUPLEX_COLLISION_DETECT_EN
    logic collision_q;

    // A peer strobe while we are driving means both ends own the bus.
    assign col_hit = (state == TX) && bus_oe && bus_stb_in;

    always_ff @(posedge clk) begin
        if (rst)
            collision_q <= 1'b0;
        else if (col_hit)
            collision_q <= 1'b1;
    end

    assign collision = collision_q;
`else
    assign col_hit   = 1'b0;
    assign collision = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        enter_turn = 1'b0;
        case (state)
            IDLE: begin
                if (tx_valid && !collision)
                    state_next = TX;
                else if (rx_en)
                    state_next = RX;
            end
            // Every TX cycle either accepts a word or hands the bus back.
            TX: begin
                if (col_hit || !accept) begin
                    state_next = TURN;
                    enter_turn = 1'b1;
                end
            end
            TURN: begin
                if (turn_done)
                    state_next = IDLE;
            end
            RX: begin
                if (!rx_en) begin
                    state_next = TURN;
                    enter_turn = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus_out     <= '0;
            bus_oe      <= 1'b0;
            bus_stb_out <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            burst_cnt   <= '0;
        end else begin
            rx_valid <= 1'b0;
            if ((state == TX) && accept && !col_hit) begin
                bus_out     <= tx_data;
                bus_oe      <= 1'b1;
                bus_stb_out <= 1'b1;
            end else begin
                bus_oe      <= 1'b0;
                bus_stb_out <= 1'b0;
            end
            if (enter_turn)
                burst_cnt <= '0;
            else if (accept)
                burst_cnt <= burst_cnt + BURST_W'(1);
            // The exit cycle from RX still captures a strobe.
            if ((state == RX) && bus_stb_in) begin
                rx_data  <= bus_in;
                rx_valid <= 1'b1;
            end
        end
    end

    turn_timer #(
        .TURN_CYC(TURN_CYC)
    ) u_turn_timer (
        .clk (clk),
        .rst (rst),
        .load(enter_turn),
        .tick(state == TURN),
        .done(turn_done)
    );

endmodule

// File: tb/tb_half_duplex_bus_ctrl.sv
// Self-checking bench for half_duplex_bus_ctrl: directed scenarios followed by
// randomized TX/RX traffic scored against a transaction-level model.
module tb_half_duplex_bus_ctrl;

    localparam int WIDTH     = 8;
    localparam int TURN_CYC  = 2;
    localparam int MAX_BURST = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             tx_valid;
    logic [WIDTH-1:0] tx_data;
    logic             tx_ready;
    logic             rx_en;
    logic             rx_valid;
    logic [WIDTH-1:0] rx_data;
    logic [WIDTH-1:0] bus_in;
    logic             bus_stb_in;
    logic [WIDTH-1:0] bus_out;
    logic             bus_oe;
    logic             bus_stb_out;
    logic             busy;
    logic             collision;

    int tests = 0;
    int fails = 0;

    // Expected per-cycle trace of the capped burst (first entry = first TX cycle).
    logic [11:0] burst_oe    = 12'b011110000110;
    logic [11:0] burst_ready = 12'b111100001110;
    logic [11:0] burst_busy  = 12'b111111101111;
    int          burst_word [12] = '{0, 1, 2, 3, 4, 0, 0, 0, 0, 5, 6, 0};

    logic [WIDTH-1:0] d;
    logic             acc_now;
    logic [WIDTH-1:0] exp_q [$];
    logic             exp_oe;
    logic             exp_rxv;
    logic [WIDTH-1:0] last_rx;
    logic             prev_oe;
    logic             seen_run;
    int               gap;
    int               run;

    always #5 clk = ~clk;

    half_duplex_bus_ctrl #(
        .WIDTH    (WIDTH),
        .TURN_CYC (TURN_CYC),
        .MAX_BURST(MAX_BURST)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready),
        .rx_en      (rx_en),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .bus_in     (bus_in),
        .bus_stb_in (bus_stb_in),
        .bus_out    (bus_out),
        .bus_oe     (bus_oe),
        .bus_stb_out(bus_stb_out),
        .busy       (busy),
        .collision  (collision)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic tv, input logic [WIDTH-1:0] td,
                                 input logic re, input logic stb,
                                 input logic [WIDTH-1:0] bi);
        tx_valid   = tv;
        tx_data    = td;
        rx_en      = re;
        bus_stb_in = stb;
        bus_in     = bi;
    endtask

    task automatic checkOutput(input string tag, input logic [WIDTH-1:0] got,
                               input logic [WIDTH-1:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic checkBit(input string tag, input logic got, input logic exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic doReset();
        rst = 1'b1;
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0);
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset state
        doReset();
        checkBit("rst_oe", bus_oe, 1'b0);
        checkOutput("rst_bus_out", bus_out, 8'h00);
        checkBit("rst_stb_out", bus_stb_out, 1'b0);
        checkBit("rst_rx_valid", rx_valid, 1'b0);
        checkOutput("rst_rx_data", rx_data, 8'h00);
        checkBit("rst_busy", busy, 1'b0);
        checkBit("rst_tx_ready", tx_ready, 1'b0);
        checkBit("rst_collision", collision, 1'b0);

        // Single word with turnaround
        applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0, '0);
        tick();
        checkBit("sw_ready", tx_ready, 1'b1);
        checkBit("sw_oe_pre", bus_oe, 1'b0);
        tick();
        checkBit("sw_oe", bus_oe, 1'b1);
        checkBit("sw_stb", bus_stb_out, 1'b1);
        checkOutput("sw_word", bus_out, 8'hA5);
        tx_valid = 1'b0;
        tick();
        checkBit("sw_turn1_oe", bus_oe, 1'b0);
        checkBit("sw_turn1_stb", bus_stb_out, 1'b0);
        checkBit("sw_turn1_busy", busy, 1'b1);
        tick();
        checkBit("sw_turn2_oe", bus_oe, 1'b0);
        checkBit("sw_turn2_busy", busy, 1'b1);
        tick();
        checkBit("sw_idle_busy", busy, 1'b0);

        // Burst cap: words 1..6 split across two ownerships
        d = 8'd1;
        applyStimulus(1'b1, d, 1'b0, 1'b0, '0);
        for (int i = 0; i < 12; i++) begin
            acc_now = tx_valid && tx_ready;
            tick();
            checkBit($sformatf("burst_oe_%0d", i), bus_oe, burst_oe[11-i]);
            checkBit($sformatf("burst_ready_%0d", i), tx_ready, burst_ready[11-i]);
            checkBit($sformatf("burst_busy_%0d", i), busy, burst_busy[11-i]);
            if (burst_oe[11-i])
                checkOutput($sformatf("burst_word_%0d", i), bus_out, 8'(burst_word[i]));
            if (acc_now)
                d = d + 8'd1;
            tx_data = d;
            if (d == 8'd7)
                tx_valid = 1'b0;
        end
        tick();
        tick();
        checkBit("burst_end_busy", busy, 1'b0);

        // Receive two back-to-back words, then a strobe on the exit cycle
        applyStimulus(1'b0, '0, 1'b1, 1'b0, '0);
        tick();
        checkBit("rx_busy", busy, 1'b1);
        applyStimulus(1'b0, '0, 1'b1, 1'b1, 8'h3C);
        tick();
        checkBit("rx_v1", rx_valid, 1'b1);
        checkOutput("rx_d1", rx_data, 8'h3C);
        applyStimulus(1'b0, '0, 1'b1, 1'b1, 8'hC3);
        tick();
        checkBit("rx_v2", rx_valid, 1'b1);
        checkOutput("rx_d2", rx_data, 8'hC3);
        checkBit("rx_oe", bus_oe, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 8'h11);
        tick();
        checkBit("rx_v3", rx_valid, 1'b0);
        checkOutput("rx_hold", rx_data, 8'hC3);
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 8'h5A);
        tick();
        checkBit("rx_exit_v", rx_valid, 1'b1);
        checkOutput("rx_exit_d", rx_data, 8'h5A);
        checkBit("rx_exit_busy", busy, 1'b1);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0);
        tick();
        checkBit("rx_turn_v", rx_valid, 1'b0);
        tick();
        checkBit("rx_idle", busy, 1'b0);

        // TX has priority; RX follows only after the turnaround
        applyStimulus(1'b1, 8'h77, 1'b1, 1'b0, '0);
        tick();
        checkBit("prio_tx", tx_ready, 1'b1);
        tick();
        checkBit("prio_oe", bus_oe, 1'b1);
        checkOutput("prio_word", bus_out, 8'h77);
        tx_valid = 1'b0;
        tick();
        checkBit("prio_t1", bus_oe, 1'b0);
        tick();
        checkBit("prio_t2_busy", busy, 1'b1);
        tick();
        checkBit("prio_idle", busy, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b1, 8'hE1);
        tick();
        checkBit("prio_rx_busy", busy, 1'b1);
        checkBit("prio_rx_ready", tx_ready, 1'b0);
        tick();
        checkBit("prio_rx_v", rx_valid, 1'b1);
        checkOutput("prio_rx_d", rx_data, 8'hE1);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0);
        tick();
        tick();
        tick();
        checkBit("prio_end_idle", busy, 1'b0);

        // Reset on the third driven word
        d = 8'h10;
        applyStimulus(1'b1, d, 1'b0, 1'b0, '0);
        for (int i = 0; i < 4; i++) begin
            acc_now = tx_valid && tx_ready;
            tick();
            if (acc_now)
                d = d + 8'd1;
            tx_data = d;
        end
        checkOutput("mid_word3", bus_out, 8'h12);
        rst = 1'b1;
        tick();
        checkBit("mid_oe", bus_oe, 1'b0);
        checkOutput("mid_bus_out", bus_out, 8'h00);
        checkBit("mid_ready", tx_ready, 1'b0);
        checkBit("mid_busy", busy, 1'b0);
        rst = 1'b0;
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0);
        tick();

        // Peer strobe while we drive the bus
        applyStimulus(1'b1, 8'h40, 1'b0, 1'b0, '0);
        tick();
        tick();
        checkBit("col_oe_pre", bus_oe, 1'b1);
`ifdef HALF_DUPLEX_COLLISION_DETECT_EN
        bus_stb_in = 1'b1;
        tick();
        checkBit("col_flag", collision, 1'b1);
        checkBit("col_oe", bus_oe, 1'b0);
        checkBit("col_stb", bus_stb_out, 1'b0);
        checkBit("col_turn", busy, 1'b1);
        bus_stb_in = 1'b0;
        tick();
        tick();
        checkBit("col_idle", busy, 1'b0);
        tick();
        checkBit("col_refuse_busy", busy, 1'b0);
        checkBit("col_refuse_ready", tx_ready, 1'b0);
        checkBit("col_sticky", collision, 1'b1);
        applyStimulus(1'b1, 8'h40, 1'b1, 1'b0, '0);
        tick();
        checkBit("col_rx_ok", busy, 1'b1);
        checkBit("col_rx_ready", tx_ready, 1'b0);
`else
        tx_data    = 8'h41;
        bus_stb_in = 1'b1;
        tick();
        checkBit("nocol_flag", collision, 1'b0);
        checkBit("nocol_oe", bus_oe, 1'b1);
        checkOutput("nocol_word", bus_out, 8'h41);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0);
        tick();
        checkBit("nocol_release", bus_oe, 1'b0);
`endif
        doReset();

        // Randomized transmit traffic against a word scoreboard
        prev_oe  = 1'b0;
        seen_run = 1'b0;
        gap      = 0;
        run      = 0;
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 9) < 7) && (i < 390), 8'($urandom),
                          1'b0, 1'b0, 8'($urandom));
            #1;
            if (tx_valid && tx_ready)
                exp_q.push_back(tx_data);
            exp_oe = (exp_q.size() != 0);
            tick();
            checkBit("rt_oe", bus_oe, exp_oe);
            checkBit("rt_stb", bus_stb_out, exp_oe);
            if (exp_oe) begin
                checkOutput("rt_word", bus_out, exp_q.pop_front());
                if (!prev_oe && seen_run)
                    checkBit("rt_turn_gap", gap >= TURN_CYC + 2, 1'b1);
                run++;
                checkBit("rt_burst_len", run <= MAX_BURST, 1'b1);
                seen_run = 1'b1;
                gap      = 0;
            end else begin
                run = 0;
                gap++;
            end
            prev_oe = exp_oe;
            checkBit("rt_sb_empty", exp_q.size() == 0, 1'b1);
        end
        checkBit("rt_drained", busy, 1'b0);

        // Randomized receive traffic
        doReset();
        last_rx = '0;
        applyStimulus(1'b0, '0, 1'b1, 1'b0, '0);
        tick();
        checkBit("rr_busy", busy, 1'b1);
        for (int i = 0; i < 150; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 8'($urandom), 1'b1,
                          1'($urandom_range(0, 1)), 8'($urandom));
            exp_rxv = bus_stb_in;
            if (bus_stb_in)
                last_rx = bus_in;
            tick();
            checkBit("rr_valid", rx_valid, exp_rxv);
            checkOutput("rr_data", rx_data, last_rx);
            checkBit("rr_oe", bus_oe, 1'b0);
        end
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0);
        for (int i = 0; i < TURN_CYC + 1; i++)
            tick();
        checkBit("rr_end_idle", busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/half_duplex_bus_ctrl.md
Name: half_duplex_bus_ctrl

Overview:
- Controller for the far end of a shared tri-state data bus: produces the enable (ctr) that top-level bufif1 primitives use to drive the bus, and samples the bus when the peer owns it.
- Owns direction switching between transmit and receive, with mandatory turnaround (all-released) cycles between owners.
- Sits between a local valid/ready word source, a local receive sink, and a per-bit bufif1 pad ring.

Parameters:
WIDTH, 8, bus and data word width in bits.
TURN_CYC, 2, number of cycles with bus_oe=0 after every ownership release (>=1).
MAX_BURST, 16, maximum words transmitted per ownership; the bus is then forcibly released.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
tx_valid  input  1  local word available
tx_data  input  WIDTH  local word
tx_ready  output  1  word accepted this cycle when tx_valid=1
rx_en  input  1  request to listen to the peer
rx_valid  output  1  one-cycle pulse: rx_data holds a new word
rx_data  output  WIDTH  last word captured from the bus
bus_in  input  WIDTH  resolved bus value from the pads
bus_stb_in  input  1  peer strobe: bus_in holds valid peer data
bus_out  output  WIDTH  value presented to the bufif1 data inputs
bus_oe  output  1  bufif1 control; 0 means the bus is released (z)
bus_stb_out  output  1  local strobe to the peer: bus_out valid
busy  output  1  state != IDLE
collision  output  1  sticky collision flag; tied 0 when the optional feature is absent

Behaviour:
- Reset: sampled at the clk edge. All outputs go to 0 (bus_out=0, rx_data=0, bus_oe=0). State=IDLE; burst and turn counters=0. Reset asserted mid-TX releases the bus at the same edge.
- All outputs except tx_ready and busy are registered. tx_ready = (state==TX) && (burst_cnt<MAX_BURST). busy is decoded from state.
- States: IDLE, TX, TURN, RX.
- IDLE:
  - If tx_valid=1, go to TX. Transmit has priority when tx_valid and rx_en are both high.
  - Else if rx_en=1, go to RX.
  - bus_oe stays 0.
- TX:
  - On accept (tx_valid && tx_ready): at the next edge, bus_out<=tx_data, bus_stb_out<=1, bus_oe<=1, burst_cnt++.
  - If tx_valid=0, or burst_cnt reaches MAX_BURST: at the next edge go to TURN with bus_oe<=0 and bus_stb_out<=0. The last accepted word has already been driven for exactly one cycle.
- Latency: tx_valid rises in IDLE at cycle N -> tx_ready=1 at N+1 -> word on bus with bus_oe=1 at N+2. Back-to-back accepts give one word per cycle.
- TURN:
  - bus_oe=0 for exactly TURN_CYC cycles, then IDLE.
  - burst_cnt clears on entry.
  - tx_valid and rx_en are ignored during TURN.
- RX:
  - bus_oe=0 throughout.
  - bus_stb_in=1 -> at the next edge rx_data<=bus_in, rx_valid<=1 for one cycle.
  - No backpressure: consecutive strobes give consecutive pulses.
  - rx_en=0 -> go to TURN. A strobe arriving in that same cycle is still captured.
- bus_stb_in outside RX is ignored, except in TX when the optional feature is enabled.
- Invariant: bus_oe=1 only in TX, or on the edge leaving TX after the final word. It is never high in RX, TURN, or IDLE.

Optional Feature:
HALF_DUPLEX_COLLISION_DETECT_EN
- Defined: bus_stb_in=1 while bus_oe=1 sets collision (sticky until rst). At the next edge bus_oe<=0, bus_stb_out<=0, and state goes to TURN. The colliding word is not retried. While collision=1, IDLE refuses TX and allows only RX.
- Undefined: no detection logic; collision tied 0; bus_stb_in has no effect in TX.

Decomposition:
- Package half_duplex_pkg: state enum (IDLE, TX, TURN, RX), state width constant, and a clog2-based counter width for TURN_CYC and MAX_BURST.
- One sub-module, turn_timer: loadable down-counter with a done pulse, parameterised by TURN_CYC. All other logic lives in the top module.

Test Plan:
- Single word: rst, then tx_valid=1, tx_data=8'hA5 for one accept -> bus_out=8'hA5, bus_oe=1, bus_stb_out=1 for exactly 1 cycle. Then bus_oe=0 for 2 cycles (TURN), then busy=0.
- Burst cap: MAX_BURST=4, tx_valid held high with data 1..6 -> words 1..4 driven on consecutive cycles, then 2 released cycles. Words 5 and 6 follow in a second ownership starting 1 cycle after IDLE.
- Receive: rx_en=1, bus_stb_in pulsed with bus_in=8'h3C then 8'hC3 on consecutive cycles -> rx_valid pulses on 2 consecutive cycles carrying 3C then C3. bus_oe stays 0 throughout.
- Priority/turnaround: tx_valid and rx_en raised together in IDLE -> TX taken first. RX is entered only after TURN_CYC released cycles and a return to IDLE.
- Reset mid-burst: rst asserted on the 3rd driven word -> at the next edge bus_oe=0, bus_out=0, tx_ready=0, busy=0.
- Collision (feature defined): bus_stb_in=1 while bus_oe=1 -> collision=1, bus_oe=0 at the next edge, state TURN. A subsequent tx_valid is refused until rst.
